fetch_prefetch_unit: RTL and testbench

Parametrised next-generation instruction fetch unit. It holds the PC and issues in-order requests to instruction memory over a valid/ready handshake, with up to QDEPTH requests in flight. Returned instructions are buffered with their PCs in a prefetch queue and presented to decode over a valid/ready handshake. A redirect input (branch/jump target) flushes the queue, discards stale in-flight responses and restarts fetch at the target. It sits between the imem port and the decode stage.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_prefetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch/prefetch block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int XLEN_DEF = 32;
   localparam int ILEN_DEF = 32;
   localparam int PC_STEP  = 4;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_FLUSH
   } fetch_state_e;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, instr}: pc slot reserved at issue, instr filled at response.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller never reserves beyond DEPTH slots.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = 32,
   parameter int DW    = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          rsv_vld_i,
   input  logic [PW-1:0] rsv_pc_i,
   input  logic          push_vld_i,
   input  logic [DW-1:0] push_dat_i,
   input  logic          pop_i,
   output logic [PW-1:0] head_pc_o,
   output logic [DW-1:0] head_dat_o,
   output logic [CW-1:0] count_o
);

   logic [PW-1:0] pc_mem_q  [DEPTH];
   logic [DW-1:0] dat_mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rsv_ptr_q;
   logic [CW-1:0] count_q;
   logic          pop;

   assign pop        = pop_i && (count_q != '0);
   assign head_pc_o  = pc_mem_q[rd_ptr_q];
   assign head_dat_o = dat_mem_q[rd_ptr_q];
   assign count_o    = count_q;

   // Pointer and occupancy update; flush empties the ring and rewinds every pointer.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         rsv_ptr_q <= '0;
         count_q   <= '0;
      end else begin
         if (rsv_vld_i)  rsv_ptr_q <= rsv_ptr_q + AW'(1);
         if (push_vld_i) wr_ptr_q  <= wr_ptr_q + AW'(1);
         if (pop)        rd_ptr_q  <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push_vld_i) - CW'(pop);
      end
   end

   // Storage: PC written when the request issues, instruction when its response returns.
   always_ff @(posedge clk) begin
      if (rsv_vld_i)  pc_mem_q[rsv_ptr_q] <= rsv_pc_i;
      if (push_vld_i) dat_mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch: issues in-order imem requests, buffers returns with PCs, redirects on branch.
// Latency: response to out_valid is one cycle; request valid is combinational only on redirect_valid.
// Backpressure: issue stalls once buffered + in-flight reaches QDEPTH; decode stalls via out_ready.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              ILEN     = ILEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] fetch_pc
);

   localparam int          CW   = cnt_w(QDEPTH);
   localparam logic [CW:0] QD_W = (CW+1)'(QDEPTH);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   outst_after;
   logic [CW-1:0]   count;
   logic [CW:0]     occ;
   logic            req_fire, out_fire, redir;
   logic            resp_live, resp_stale, push;
   logic            unused_tgt_lo;

   assign unused_tgt_lo  = ^redirect_target[1:0];

   assign occ            = {1'b0, count} + {1'b0, outst_q};
   assign imem_req_valid = (state_q == S_RUN) && !redirect_valid && (occ < QD_W);
   assign imem_req_addr  = fetch_pc_q;
   assign fetch_pc       = fetch_pc_q;
   assign out_valid      = (count != '0);

   assign req_fire    = imem_req_valid && imem_req_ready;
   assign out_fire    = out_valid && out_ready;
   assign redir       = redirect_valid && (state_q != S_BOOT);
   // A response belongs to a live request only once every stale one has drained.
   assign resp_live   = imem_resp_valid && (drop_cnt_q == '0);
   assign resp_stale  = imem_resp_valid && (drop_cnt_q != '0);
   assign push        = resp_live && !redir;
   assign outst_after = outst_q + CW'(req_fire) - CW'(resp_live);

   // Next-state: redirect turns all live in-flight requests into stale ones to drop.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_after;
      drop_cnt_d = drop_cnt_q - CW'(resp_stale);
      if (redir) begin
         fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
         outst_d    = '0;
         drop_cnt_d = drop_cnt_q - CW'(resp_stale) + outst_after;
         state_d    = (drop_cnt_d != '0) ? S_FLUSH : S_RUN;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
         case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_FLUSH: if (drop_cnt_d == '0) state_d = S_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // FSM and fetch bookkeeping registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_BOOT;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .DEPTH (QDEPTH),
      .PW    (XLEN),
      .DW    (ILEN)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (redir),
      .rsv_vld_i  (req_fire),
      .rsv_pc_i   (fetch_pc_q),
      .push_vld_i (push),
      .push_dat_i (imem_resp_data),
      .pop_i      (out_fire),
      .head_pc_o  (out_pc),
      .head_dat_o (out_instr),
      .count_o    (count)
   );

   // Reserved plus buffered entries can never exceed the queue depth.
   a_occ_bound : assert property (@(posedge clk) disable iff (reset) occ <= QD_W);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order imem model of configurable latency.
// Latency: imem response arrives lat cycles after the accepting edge.
// Backpressure: out_ready driven per scenario; imem always ready.
module tb_fetch_prefetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] fetch_pc;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int lat     = 1;

   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] req_log[$];
   logic [31:0] out_pc_log[$];
   logic [31:0] out_ins_log[$];

   fetch_prefetch_unit #(
      .XLEN     (32),
      .ILEN     (32),
      .RESET_PC (32'h0000_0100),
      .QDEPTH   (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .fetch_pc        (fetch_pc)
   );

   always #5 clk = ~clk;

   // imem model plus transaction logging, evaluated mid-cycle when all inputs are stable.
   always @(negedge clk) begin
      cyc = cyc + 1;
      imem_resp_valid = 1'b0;
      if (reset) begin
         pend_addr.delete();
         pend_due.delete();
      end else begin
         if (out_valid && out_ready) begin
            out_pc_log.push_back(out_pc);
            out_ins_log.push_back(out_instr);
         end
         if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
         end
         if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr[0] + 32'h1000_0000;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
      end
   end

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves reset asserted for one edge; the caller releases it.
   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      req_log.delete();
      out_pc_log.delete();
      out_ins_log.delete();
      step(1);
   endtask

   initial begin
      // Streaming fetch, latency 1, decode always ready.
      lat = 1;
      out_ready = 1'b1;
      step(1);
      do_reset();
      chk_val("rst_out_valid", out_valid, 0);
      chk_val("rst_req_valid", imem_req_valid, 0);
      chk_val("rst_fetch_pc", fetch_pc, 32'h100);
      chk_val("rst_state", dut.state_q, S_BOOT);
      chk_val("rst_drop", dut.drop_cnt_q, 0);
      reset = 1'b0;
      step(1);
      chk_val("s1_state_run", dut.state_q, S_RUN);
      chk_val("s1_req_valid", imem_req_valid, 1);
      chk_val("s1_req_addr", imem_req_addr, 32'h100);
      step(1);
      chk_val("s1_out_empty", out_valid, 0);
      chk_val("s1_fetch_pc", fetch_pc, 32'h104);
      step(1);
      chk_val("s1_first_valid", out_valid, 1);
      chk_val("s1_first_pc", out_pc, 32'h100);
      chk_val("s1_first_ins", out_instr, 32'h1000_0100);
      step(1);
      chk_val("s1_second_pc", out_pc, 32'h104);
      step(6);
      chk_val("s1_req3", req_log[3], 32'h10C);
      chk_val("s1_out2_pc", out_pc_log[2], 32'h108);
      chk_val("s1_out2_ins", out_ins_log[2], 32'h1000_0108);

      // Decode stalled: exactly QDEPTH requests, then resume at 0x110.
      out_ready = 1'b0;
      do_reset();
      reset = 1'b0;
      step(12);
      chk_val("s2_req_count", req_log.size(), 4);
      chk_val("s2_req3", req_log[3], 32'h10C);
      chk_val("s2_req_stall", imem_req_valid, 0);
      chk_val("s2_fetch_pc", fetch_pc, 32'h110);
      chk_val("s2_head_pc", out_pc, 32'h100);
      out_ready = 1'b1;
      step(1);
      chk_val("s2_resume_vld", imem_req_valid, 1);
      chk_val("s2_resume_addr", imem_req_addr, 32'h110);
      chk_val("s2_head_next", out_pc, 32'h104);

      // Three requests in flight, redirect to misaligned target.
      lat = 4;
      do_reset();
      reset = 1'b0;
      step(4);
      chk_val("s3_inflight", req_log.size(), 3);
      redirect_valid = 1'b1;
      redirect_target = 32'h203;
      #1;
      chk_val("s3_req_gated", imem_req_valid, 0);
      step(1);
      redirect_valid = 1'b0;
      chk_val("s3_fetch_pc", fetch_pc, 32'h200);
      chk_val("s3_state_flush", dut.state_q, S_FLUSH);
      chk_val("s3_drop3", dut.drop_cnt_q, 3);
      chk_val("s3_no_req", imem_req_valid, 0);
      step(1);
      chk_val("s3_drop2", dut.drop_cnt_q, 2);
      step(2);
      chk_val("s3_drop0", dut.drop_cnt_q, 0);
      chk_val("s3_state_run", dut.state_q, S_RUN);
      chk_val("s3_out_empty", out_valid, 0);
      step(8);
      chk_val("s3_out_count", out_pc_log.size() >= 1, 1);
      chk_val("s3_out0_pc", out_pc_log[0], 32'h200);
      chk_val("s3_out0_ins", out_ins_log[0], 32'h1000_0200);

      // Redirect coinciding with a response and an out fire.
      lat = 1;
      do_reset();
      reset = 1'b0;
      step(6);
      chk_val("s4_head_pc", out_pc, 32'h10C);
      redirect_valid = 1'b1;
      redirect_target = 32'h300;
      step(1);
      redirect_valid = 1'b0;
      chk_val("s4_out_empty", out_valid, 0);
      chk_val("s4_drop0", dut.drop_cnt_q, 0);
      chk_val("s4_state_run", dut.state_q, S_RUN);
      chk_val("s4_fetch_pc", fetch_pc, 32'h300);
      chk_val("s4_log_len", out_pc_log.size(), 4);
      chk_val("s4_popped_pc", out_pc_log[3], 32'h10C);
      step(4);
      chk_val("s4_next_pc", out_pc_log[4], 32'h300);
      chk_val("s4_next_ins", out_ins_log[4], 32'h1000_0300);

      // Address wrap at the top of the space.
      do_reset();
      reset = 1'b0;
      step(1);
      redirect_valid = 1'b1;
      redirect_target = 32'hFFFF_FFF8;
      step(1);
      redirect_valid = 1'b0;
      chk_val("s5_fetch_pc", fetch_pc, 32'hFFFF_FFF8);
      chk_val("s5_no_req_yet", req_log.size(), 0);
      step(8);
      chk_val("s5_req0", req_log[0], 32'hFFFF_FFF8);
      chk_val("s5_req1", req_log[1], 32'hFFFF_FFFC);
      chk_val("s5_req2", req_log[2], 32'h0000_0000);
      chk_val("s5_out1_pc", out_pc_log[1], 32'hFFFF_FFFC);
      chk_val("s5_out1_ins", out_ins_log[1], 32'h0FFF_FFFC);
      chk_val("s5_out2_pc", out_pc_log[2], 32'h0000_0000);

      // Reset while flushing two stale requests.
      lat = 4;
      do_reset();
      reset = 1'b0;
      step(3);
      redirect_valid = 1'b1;
      redirect_target = 32'h400;
      step(1);
      redirect_valid = 1'b0;
      chk_val("s6_state_flush", dut.state_q, S_FLUSH);
      chk_val("s6_drop2", dut.drop_cnt_q, 2);
      do_reset();
      chk_val("s6_out_valid", out_valid, 0);
      chk_val("s6_drop0", dut.drop_cnt_q, 0);
      chk_val("s6_fetch_pc", fetch_pc, 32'h100);
      chk_val("s6_state_boot", dut.state_q, S_BOOT);
      chk_val("s6_req_valid", imem_req_valid, 0);
      reset = 1'b0;
      step(8);
      chk_val("s6_restart_pc", out_pc_log[0], 32'h100);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
